// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS subset core: one shared request/ready memory port,
// FSM-sequenced fetch/decode/execute/memory/writeback, retire strobe and sticky halt.
module mips_multicycle_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc_out,
   output logic        retire,
   output logic        halt
);

   localparam int RW = $clog2(NUM_REGS);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
      S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, ir_reg, a_reg, b_reg, aluout_reg, mdr_reg;
   logic [31:0] rf [NUM_REGS];

   logic [5:0]    opcode, funct;
   logic [RW-1:0] rs_idx, rt_idx, rd_idx;
   logic [31:0]   imm_sext;

   logic          req_state;
   logic          rf_we;
   logic [RW-1:0] rf_waddr;
   logic [31:0]   rf_wdata;
   logic [31:0]   alu_r;
   logic          funct_ok;

   // Register indices wrap modulo NUM_REGS by keeping only the low bits.
   assign opcode   = ir_reg[31:26];
   assign funct    = ir_reg[5:0];
   assign rs_idx   = ir_reg[21 +: RW];
   assign rt_idx   = ir_reg[16 +: RW];
   assign rd_idx   = ir_reg[11 +: RW];
   assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};

   always_comb begin
      alu_r    = 32'h0;
      funct_ok = 1'b1;
      case (funct)
         6'h20:   alu_r = a_reg + b_reg;
         6'h22:   alu_r = a_reg - b_reg;
         6'h24:   alu_r = a_reg & b_reg;
         6'h25:   alu_r = a_reg | b_reg;
         6'h2A:   alu_r = ($signed(a_reg) < $signed(b_reg)) ? 32'h1 : 32'h0;
         default: funct_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      req_state  = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = pc_reg;
      mem_wdata  = b_reg;
      retire     = 1'b0;
      rf_we      = 1'b0;
      rf_waddr   = rd_idx;
      rf_wdata   = aluout_reg;
      case (state_reg)
         S_FETCH: begin
            req_state = 1'b1;
            if (mem_ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               6'h00:        state_next = S_EXEC_R;
               6'h23, 6'h2B: state_next = S_MEM_ADDR;
               6'h08:        state_next = S_EXEC_I;
               6'h04:        state_next = S_BRANCH;
               6'h02:        state_next = S_JUMP;
               default:      state_next = S_HALT;
            endcase
         end
         S_EXEC_R: state_next = funct_ok ? S_WB_R : S_HALT;
         S_WB_R: begin
            rf_we      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_EXEC_I: state_next = S_WB_I;
         S_WB_I: begin
            rf_we      = 1'b1;
            rf_waddr   = rt_idx;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_ADDR: state_next = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            req_state = 1'b1;
            mem_addr  = aluout_reg;
            if (mem_ready) state_next = S_WB_MEM;
         end
         S_WB_MEM: begin
            rf_we      = 1'b1;
            rf_waddr   = rt_idx;
            rf_wdata   = mdr_reg;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WR: begin
            req_state = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = aluout_reg;
            if (mem_ready) begin
               retire     = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_BRANCH, S_JUMP: begin
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   // The reset state is FETCH, so the request is masked while reset is held.
   assign mem_req = req_state & rst_n;
   assign halt    = (state_reg == S_HALT);
   assign pc_out  = pc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg     <= RESET_PC;
         ir_reg     <= 32'h0;
         a_reg      <= 32'h0;
         b_reg      <= 32'h0;
         aluout_reg <= 32'h0;
         mdr_reg    <= 32'h0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               if (mem_ready) begin
                  ir_reg <= mem_rdata;
                  pc_reg <= pc_reg + 32'd4;
               end
            end
            S_DECODE: begin
               a_reg      <= rf[rs_idx];
               b_reg      <= rf[rt_idx];
               aluout_reg <= pc_reg + {imm_sext[29:0], 2'b00};
            end
            S_EXEC_R: begin
               if (funct_ok) aluout_reg <= alu_r;
            end
            S_EXEC_I, S_MEM_ADDR: aluout_reg <= a_reg + imm_sext;
            S_MEM_RD: begin
               if (mem_ready) mdr_reg <= mem_rdata;
            end
            S_BRANCH: begin
               if (a_reg == b_reg) pc_reg <= aluout_reg;
            end
            S_JUMP:  pc_reg <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
            default: ;
         endcase
      end
   end

   // Register 0 is never written, so it always reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= 32'h0;
      end else if (rf_we && (rf_waddr != '0)) begin
         rf[rf_waddr] <= rf_wdata;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Self-checking bench: instruction-level ISA model with cycle table versus the multi-cycle core.
module tb_mips_multicycle_cpu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req, mem_we, mem_ready, retire, halt;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

   logic        rst_n_8;
   logic        mem_req_8, mem_we_8, mem_ready_8, retire_8, halt_8;
   logic [31:0] mem_addr_8, mem_wdata_8, mem_rdata_8, pc_out_8;

   always #5 clk = ~clk;

   mips_multicycle_cpu #(.RESET_PC(32'h0), .NUM_REGS(32)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .pc_out(pc_out), .retire(retire), .halt(halt));

   mips_multicycle_cpu #(.RESET_PC(32'h0), .NUM_REGS(8)) dut8 (
      .clk(clk), .rst_n(rst_n_8), .mem_req(mem_req_8), .mem_we(mem_we_8),
      .mem_addr(mem_addr_8), .mem_wdata(mem_wdata_8), .mem_rdata(mem_rdata_8),
      .mem_ready(mem_ready_8), .pc_out(pc_out_8), .retire(retire_8), .halt(halt_8));

   // Memory: 1 KB, read data combinational, ready after wait_cycles request cycles.
   logic [31:0] mem [256];
   logic [31:0] mem8 [64];
   int          wait_cycles;
   int          wait_cnt;

   assign mem_ready   = mem_req && (wait_cnt >= wait_cycles);
   assign mem_rdata   = mem[mem_addr[9:2]];
   assign mem_ready_8 = mem_req_8;
   assign mem_rdata_8 = mem8[mem_addr_8[7:2]];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt <= 0;
      else if (mem_req) wait_cnt <= mem_ready ? 0 : wait_cnt + 1;
   end

   int check_cnt = 0;
   int pass_cnt  = 0;

   // ISA reference model
   logic [31:0] m_regs [32];
   logic [31:0] m_mem [256];
   logic [31:0] m_pc;
   int          m_nregs = 32;
   logic [31:0] fetch_log [$];
   int          cyc_log [$];

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic void model_step(output int cyc, output bit hlt, output bit st,
                                      output logic [31:0] sa, output logic [31:0] sd);
      logic [31:0] ir, a, b, simm, r, ea;
      int rs, rt, rd;
      bit ok;
      ir   = m_mem[m_pc[9:2]];
      rs   = int'(ir[25:21]) % m_nregs;
      rt   = int'(ir[20:16]) % m_nregs;
      rd   = int'(ir[15:11]) % m_nregs;
      a    = m_regs[rs];
      b    = m_regs[rt];
      simm = {{16{ir[15]}}, ir[15:0]};
      ea   = a + simm;
      m_pc = m_pc + 32'd4;
      cyc = 0; hlt = 0; st = 0; sa = 0; sd = 0; r = 0; ok = 1;
      case (ir[31:26])
         6'h00: begin
            case (ir[5:0])
               6'h20: r = a + b;
               6'h22: r = a - b;
               6'h24: r = a & b;
               6'h25: r = a | b;
               6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: ok = 0;
            endcase
            if (ok) begin
               if (rd != 0) m_regs[rd] = r;
               cyc = 4 + wait_cycles;
            end else hlt = 1;
         end
         6'h08: begin
            if (rt != 0) m_regs[rt] = ea;
            cyc = 4 + wait_cycles;
         end
         6'h23: begin
            if (rt != 0) m_regs[rt] = m_mem[ea[9:2]];
            cyc = 5 + 2 * wait_cycles;
         end
         6'h2B: begin
            st = 1; sa = ea; sd = b;
            m_mem[ea[9:2]] = b;
            cyc = 4 + 2 * wait_cycles;
         end
         6'h04: begin
            if (a == b) m_pc = m_pc + {simm[29:0], 2'b00};
            cyc = 3 + wait_cycles;
         end
         6'h02: begin
            m_pc = {m_pc[31:28], ir[25:0], 2'b00};
            cyc = 3 + wait_cycles;
         end
         default: hlt = 1;
      endcase
   endfunction

   task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
      mem[addr[9:2]]   = data;
      m_mem[addr[9:2]] = data;
   endtask

   task automatic reset_cpu(input int w);
      rst_n = 1'b0;
      wait_cycles = w;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'h0;
         m_mem[i] = 32'h0;
      end
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_pc = 32'h0;
      fetch_log.delete();
      cyc_log.delete();
      @(posedge clk);
   endtask

   task automatic start_cpu;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Runs instructions in lockstep with the model until the model PC reaches end_pc or halts.
   task automatic run_prog(input logic [31:0] end_pc, input int max_instr);
      int n = 0;
      while (m_pc != end_pc && n < max_instr) begin
         logic [31:0] fpc, eaddr, edata;
         int ecyc, cycles;
         bit ehlt, est, done, saw_store, st_ok;
         fpc = m_pc;
         model_step(ecyc, ehlt, est, eaddr, edata);
         cycles = 0; done = 0; saw_store = 0; st_ok = 1;
         while (!done) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
               fetch_log.push_back(mem_addr);
               check_cnt++;
               if (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === fpc))
                  $display("FAIL fetch: req=%b we=%b addr=%h, required req=1 we=0 addr=%h",
                           mem_req, mem_we, mem_addr, fpc);
               else pass_cnt++;
            end
            if (mem_req && mem_we) begin
               saw_store = 1;
               if (mem_addr !== eaddr || mem_wdata !== edata) st_ok = 0;
               if (mem_ready) mem[mem_addr[9:2]] = mem_wdata;
            end
            if (retire === 1'b1 || halt === 1'b1 || cycles >= 60) done = 1;
         end
         cyc_log.push_back(cycles);
         if (ehlt) begin
            check_cnt++;
            if (!(halt === 1'b1 && retire === 1'b0))
               $display("FAIL halt_entry @%h: halt=%b retire=%b, required halt=1 retire=0",
                        fpc, halt, retire);
            else pass_cnt++;
            break;
         end
         check_cnt++;
         if (!(retire === 1'b1 && halt === 1'b0 && cycles == ecyc))
            $display("FAIL retire_cycles @%h: retire=%b after %0d cycles, required retire=1 after %0d",
                     fpc, retire, cycles, ecyc);
         else pass_cnt++;
         check_cnt++;
         if (saw_store != est || !st_ok)
            $display("FAIL store @%h: seen=%b stable_match=%b, required seen=%b addr=%h data=%h",
                     fpc, saw_store, st_ok, est, eaddr, edata);
         else pass_cnt++;
         if (cycles >= 60) break;
         n++;
      end
   endtask

   task automatic test_reset;
      reset_cpu(0);
      load_word(32'h0, enc_i(6'h08, 5'd0, 5'd1, 16'd1));
      @(negedge clk);
      check_cnt++;
      if (!(mem_req === 1'b0 && pc_out === 32'h0 && retire === 1'b0 && halt === 1'b0))
         $display("FAIL reset_hold: req=%b pc=%h retire=%b halt=%b, required 0/0/0/0",
                  mem_req, pc_out, retire, halt);
      else pass_cnt++;
      start_cpu();
      @(negedge clk);
      check_cnt++;
      if (!(pc_out === 32'h0 && mem_req === 1'b1 && mem_addr === 32'h0 && mem_we === 1'b0))
         $display("FAIL first_fetch: pc=%h req=%b addr=%h we=%b, required pc=0 req=1 addr=0 we=0",
                  pc_out, mem_req, mem_addr, mem_we);
      else pass_cnt++;
      @(negedge clk);
      check_cnt++;
      if (pc_out !== 32'h4) $display("FAIL pc_incr: pc=%h, required 00000004", pc_out);
      else pass_cnt++;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_cnt++;
      if (!(pc_out === 32'h0 && mem_req === 1'b0))
         $display("FAIL async_reset: pc=%h req=%b, required pc=0 req=0", pc_out, mem_req);
      else pass_cnt++;
   endtask

   task automatic test_alu;
      bit all4;
      reset_cpu(0);
      load_word(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
      load_word(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
      load_word(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
      load_word(32'h0C, enc_r(5'd2, 5'd1, 5'd4, 6'h22));
      load_word(32'h10, enc_r(5'd2, 5'd1, 5'd5, 6'h2A));
      load_word(32'h14, enc_i(6'h08, 5'd0, 5'd0, 16'd9));
      load_word(32'h18, enc_i(6'h2B, 5'd0, 5'd3, 16'h0200));
      load_word(32'h1C, enc_i(6'h2B, 5'd0, 5'd4, 16'h0204));
      load_word(32'h20, enc_i(6'h2B, 5'd0, 5'd5, 16'h0208));
      load_word(32'h24, enc_i(6'h2B, 5'd0, 5'd0, 16'h020C));
      start_cpu();
      run_prog(32'h28, 20);
      check_cnt++;
      if (!(mem[128] === 32'd2 && mem[129] === 32'hFFFF_FFF8 && mem[130] === 32'd1 && mem[131] === 32'd0))
         $display("FAIL alu_results: $3=%h $4=%h $5=%h $0=%h, required 2 fffffff8 1 0",
                  mem[128], mem[129], mem[130], mem[131]);
      else pass_cnt++;
      all4 = (cyc_log.size() >= 6);
      for (int i = 0; i < 6 && i < cyc_log.size(); i++) if (cyc_log[i] != 4) all4 = 0;
      check_cnt++;
      if (!all4) $display("FAIL alu_cpi: first cycle count=%0d, required every ALU op = 4",
                          (cyc_log.size() > 0) ? cyc_log[0] : -1);
      else pass_cnt++;
   endtask

   task automatic test_load_store;
      reset_cpu(3);
      load_word(32'h00, {6'h02, 26'h10});
      load_word(32'h40, enc_i(6'h08, 5'd0, 5'd3, 16'd2));
      load_word(32'h44, enc_i(6'h2B, 5'd0, 5'd3, 16'd8));
      load_word(32'h48, enc_i(6'h23, 5'd0, 5'd6, 16'd8));
      load_word(32'h4C, enc_i(6'h2B, 5'd0, 5'd6, 16'h0210));
      start_cpu();
      run_prog(32'h50, 10);
      check_cnt++;
      if (!(mem[2] === 32'd2 && mem[132] === 32'd2))
         $display("FAIL load_store: mem[8]=%h $6=%h, required 2 and 2", mem[2], mem[132]);
      else pass_cnt++;
      check_cnt++;
      if (!(cyc_log.size() >= 4 && cyc_log[2] == 10 && cyc_log[3] == 11))
         $display("FAIL ls_cpi: sw=%0d lw=%0d cycles, required 10 and 11",
                  (cyc_log.size() > 2) ? cyc_log[2] : -1, (cyc_log.size() > 3) ? cyc_log[3] : -1);
      else pass_cnt++;
   endtask

   task automatic test_branch_jump;
      reset_cpu(0);
      load_word(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd1));
      load_word(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd2));
      load_word(32'h08, enc_i(6'h08, 5'd0, 5'd0, 16'd0));
      load_word(32'h0C, enc_i(6'h04, 5'd1, 5'd2, 16'd7));
      load_word(32'h10, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
      load_word(32'h14, enc_i(6'h08, 5'd0, 5'd1, 16'h55));
      load_word(32'h18, enc_i(6'h08, 5'd0, 5'd1, 16'h66));
      load_word(32'h1C, enc_i(6'h04, 5'd1, 5'd2, 16'd5));
      load_word(32'h20, {6'h02, 26'h40});
      load_word(32'h100, enc_i(6'h2B, 5'd0, 5'd1, 16'h0200));
      start_cpu();
      run_prog(32'h104, 20);
      check_cnt++;
      if (!(fetch_log.size() >= 8 && fetch_log[4] === 32'h10 && fetch_log[5] === 32'h1C
            && fetch_log[6] === 32'h20 && fetch_log[7] === 32'h100))
         $display("FAIL branch_jump: fetches=%0d f4=%h f5=%h f6=%h f7=%h, required 10 1c 20 100",
                  fetch_log.size(), (fetch_log.size() > 4) ? fetch_log[4] : 32'hx,
                  (fetch_log.size() > 5) ? fetch_log[5] : 32'hx,
                  (fetch_log.size() > 6) ? fetch_log[6] : 32'hx,
                  (fetch_log.size() > 7) ? fetch_log[7] : 32'hx);
      else pass_cnt++;
      check_cnt++;
      if (mem[128] !== 32'd1) $display("FAIL branch_skip: $1=%h, required 1", mem[128]);
      else pass_cnt++;
   endtask

   task automatic test_halt(input logic [31:0] bad_word, input string name);
      bit frozen;
      logic [31:0] exp_pc;
      reset_cpu(1);
      load_word(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd1));
      load_word(32'h04, bad_word);
      start_cpu();
      run_prog(32'hFFFF_FFF0, 2);
      exp_pc = m_pc;
      frozen = 1;
      repeat (8) begin
         @(negedge clk);
         if (!(halt === 1'b1 && mem_req === 1'b0 && retire === 1'b0 && pc_out === exp_pc)) frozen = 0;
      end
      check_cnt++;
      if (!frozen)
         $display("FAIL %s_sticky: halt=%b req=%b retire=%b pc=%h, required 1 0 0 pc=%h",
                  name, halt, mem_req, retire, pc_out, exp_pc);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      check_cnt++;
      if (!(halt === 1'b0 && pc_out === 32'h0))
         $display("FAIL %s_clear: halt=%b pc=%h, required halt=0 pc=0", name, halt, pc_out);
      else pass_cnt++;
   endtask

   task automatic test_random(input int w, input int n);
      logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      reset_cpu(w);
      for (int k = 128; k < 160; k++) begin
         logic [31:0] d;
         d = $urandom();
         mem[k] = d;
         m_mem[k] = d;
      end
      for (int i = 0; i < n; i++) begin
         logic [4:0] ra, rb, rc;
         logic [15:0] off;
         int kind;
         ra = 5'($urandom_range(0, 7));
         rb = 5'($urandom_range(0, 7));
         rc = 5'($urandom_range(0, 7));
         off = 16'(16'h0200 + 4 * $urandom_range(0, 31));
         kind = (i == n - 1) ? 0 : $urandom_range(0, 5);
         case (kind)
            1: load_word(32'(4 * i), enc_r(ra, rb, rc, fns[$urandom_range(0, 4)]));
            2: load_word(32'(4 * i), enc_i(6'h2B, 5'd0, rb, off));
            3: load_word(32'(4 * i), enc_i(6'h23, 5'd0, rb, off));
            4: load_word(32'(4 * i), enc_i(6'h04, ra, rb, 16'($urandom_range(0, 1))));
            default: load_word(32'(4 * i), enc_i(6'h08, ra, rb, 16'($urandom_range(0, 65535))));
         endcase
      end
      for (int r = 1; r < 8; r++)
         load_word(32'(4 * (n + r - 1)), enc_i(6'h2B, 5'd0, 5'(r), 16'(16'h0280 + 4 * r)));
      start_cpu();
      run_prog(32'(4 * (n + 7)), 200);
      check_cnt++;
      if (m_pc !== 32'(4 * (n + 7)))
         $display("FAIL random_complete: model pc=%h, required %h", m_pc, 32'(4 * (n + 7)));
      else pass_cnt++;
   endtask

   task automatic test_num_regs8;
      int nret = 0;
      rst_n_8 = 1'b0;
      for (int i = 0; i < 64; i++) mem8[i] = 32'h0;
      mem8[0] = enc_i(6'h08, 5'd0, 5'd9, 16'd7);
      mem8[1] = enc_i(6'h08, 5'd1, 5'd10, 16'd1);
      mem8[2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0080);
      mem8[3] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0084);
      mem8[4] = enc_i(6'h2B, 5'd0, 5'd10, 16'h0088);
      @(posedge clk);
      #1 rst_n_8 = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (mem_req_8 && mem_we_8 && mem_addr_8 < 32'd256) mem8[mem_addr_8[7:2]] = mem_wdata_8;
         if (retire_8) nret++;
         if (halt_8) break;
      end
      check_cnt++;
      if (!(mem8[32] === 32'd7 && mem8[33] === 32'd8 && mem8[34] === 32'd8))
         $display("FAIL regs8_wrap: $1=%h $2=%h $10=%h, required 7 8 8", mem8[32], mem8[33], mem8[34]);
      else pass_cnt++;
      check_cnt++;
      if (!(halt_8 === 1'b1 && nret == 5 && pc_out_8 === 32'h18))
         $display("FAIL regs8_end: halt=%b retires=%0d pc=%h, required 1 5 00000018",
                  halt_8, nret, pc_out_8);
      else pass_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      rst_n_8 = 1'b0;
      wait_cycles = 0;
      test_reset();
      test_alu();
      test_load_store();
      test_branch_jump();
      test_halt(32'hFC00_0000, "illegal_opcode");
      test_halt(enc_r(5'd1, 5'd1, 5'd1, 6'h3F), "illegal_funct");
      test_random(0, 30);
      test_random(2, 30);
      test_num_regs8();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
